c17_bist_sequencer: RTL and testbench

- Built-in self-test sequencer for the 5-input/2-output NAND benchmark netlist (inputs N1,N2,N3,N6,N7; outputs N22,N23).
- Drives one pattern at a time and holds it long enough to cover the netlist's worst gate-delay path.
- Captures both outputs into a 16-bit MISR, then compares the final signature to a golden value and reports pass/fail.
- Sits beside the generated netlist in the timing-simulation top level; the netlist itself is unchanged.

---
 rtl/c17_bist_sequencer.sv | 138 +++++++++++++
 tb/tb_c17_bist_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/c17_bist_sequencer.sv
// BIST sequencer for the c17 NAND benchmark: applies patterns, waits out the
// worst gate-delay path, compacts both outputs into a 16-bit MISR and checks it.
module c17_bist_sequencer #(
    parameter int          NUM_PATTERNS  = 32,
    parameter int          SETTLE_CYCLES = 11,
    parameter logic [15:0] SIG_POLY      = 16'h1021
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] golden_sig,
    output logic [4:0]  dut_in,
    input  logic [1:0]  dut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [4:0]  pattern_idx
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_APPLY   = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int               CNT_W     = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [4:0]       LAST_IDX  = 5'(NUM_PATTERNS - 1);
    localparam logic [4:0]       LFSR_SEED = 5'b00001;

    logic [2:0]       state_q, state_d;
    logic             mode_q, mode_d;
    logic [4:0]       dut_in_q, dut_in_d;
    logic [4:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [15:0]      sig_q, sig_d;

    logic [4:0]  next_pattern;
    logic [15:0] sig_next;

    always_comb begin
        next_pattern = mode_q ? {dut_in_q[3:0], dut_in_q[4] ^ dut_in_q[2]} : idx_q + 5'd1;
        sig_next     = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? SIG_POLY : 16'h0000) ^ {14'b0, dut_out};
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        dut_in_d = dut_in_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        sig_d    = sig_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    sig_d    = 16'h0000;
                    idx_d    = 5'd0;
                    dut_in_d = mode ? LFSR_SEED : 5'd0;
                    pass_d   = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_APPLY;
                end
            end
            S_APPLY: begin
                cnt_d   = CNT_LOAD;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // Counter runs SETTLE_CYCLES-1 down to 0, giving exactly SETTLE_CYCLES cycles.
                if (cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                sig_d = sig_next;
                if (idx_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d    = idx_q + 5'd1;
                    dut_in_d = next_pattern;
                    state_d  = S_APPLY;
                end
            end
            S_DONE: begin
                pass_d  = (sig_q == golden_sig);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            dut_in_q <= 5'd0;
            idx_q    <= 5'd0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            sig_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            dut_in_q <= dut_in_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            sig_q    <= sig_d;
        end
    end

    assign dut_in      = dut_in_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign signature   = sig_q;
    assign pattern_idx = idx_q;

endmodule

// File: tb/tb_c17_bist_sequencer.sv
// Randomized bench for c17_bist_sequencer: a c17 netlist model with per-pattern
// output flips feeds the sequencer, and a pattern-list/MISR model predicts every cycle.
module tb_c17_bist_sequencer;

    localparam int NP    = 32;
    localparam int ST    = 11;
    localparam int PER   = ST + 2;
    localparam int TOTAL = NP * PER;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [15:0] golden_sig;
    logic [4:0]  dut_in;
    logic [1:0]  dut_out;
    logic        busy, done, pass;
    logic [15:0] signature;
    logic [4:0]  pattern_idx;

    logic        s_start, s_mode;
    logic [15:0] s_golden;
    logic [4:0]  s_dut_in;
    logic [1:0]  s_dut_out;
    logic        s_busy, s_done, s_pass;
    logic [15:0] s_signature;
    logic [4:0]  s_pattern_idx;

    logic        tie0;
    logic [1:0]  flip_tab [32];

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [1:0] c17(input logic [4:0] v);
        logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
        {n1, n2, n3, n6, n7} = v;
        n10 = ~(n1 & n3);
        n11 = ~(n3 & n6);
        n16 = ~(n2 & n11);
        n19 = ~(n11 & n7);
        return {~(n10 & n16), ~(n16 & n19)};
    endfunction

    function automatic logic [1:0] out_model(input logic [4:0] p);
        return tie0 ? 2'b00 : (c17(p) ^ flip_tab[p]);
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, d};
    endfunction

    assign dut_out   = out_model(dut_in);
    assign s_dut_out = 2'b01;

    c17_bist_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .golden_sig(golden_sig),
        .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
        .signature(signature), .pattern_idx(pattern_idx)
    );

    c17_bist_sequencer #(.NUM_PATTERNS(4), .SETTLE_CYCLES(2), .SIG_POLY(16'h1021)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .mode(s_mode), .golden_sig(s_golden),
        .dut_in(s_dut_in), .dut_out(s_dut_out), .busy(s_busy), .done(s_done), .pass(s_pass),
        .signature(s_signature), .pattern_idx(s_pattern_idx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with the main instance idle; returns at the
    // falling edge of the IDLE cycle that follows DONE.
    task automatic do_run(input string name, input logic m, input bit use_model_gold,
                          input logic [15:0] gval, input bit hold);
        logic [4:0]  pat [NP];
        logic [15:0] sig_tab [NP+1];
        logic [4:0]  p;
        logic [15:0] gold;
        int          k;
        p = m ? 5'd1 : 5'd0;
        for (int i = 0; i < NP; i++) begin
            pat[i] = p;
            p = m ? {p[3:0], p[4] ^ p[2]} : p + 5'd1;
        end
        sig_tab[0] = 16'h0000;
        for (int i = 0; i < NP; i++) sig_tab[i+1] = misr_step(sig_tab[i], out_model(pat[i]));
        gold = use_model_gold ? sig_tab[NP] : gval;

        start      = 1'b1;
        mode       = m;
        golden_sig = gold;
        @(posedge clk);
        for (int j = 0; j <= TOTAL; j++) begin
            @(negedge clk);
            if (j == 0) check($sformatf("%s pass_cleared", name), 32'(pass), 32'(1'b0));
            if (j < TOTAL) begin
                k = j / PER;
                check($sformatf("%s dut_in j=%0d", name, j), 32'(dut_in), 32'(pat[k]));
                check($sformatf("%s idx j=%0d", name, j), 32'(pattern_idx), 32'(k));
                check($sformatf("%s busy j=%0d", name, j), 32'(busy), 32'(1'b1));
                check($sformatf("%s done j=%0d", name, j), 32'(done), 32'(1'b0));
                if (j % PER == 0)
                    check($sformatf("%s sig j=%0d", name, j), 32'(signature), 32'(sig_tab[k]));
                start = 1'($urandom);
                mode  = 1'($urandom);
            end else begin
                check($sformatf("%s done_at_%0d", name, TOTAL), 32'(done), 32'(1'b1));
                check($sformatf("%s busy_in_done", name), 32'(busy), 32'(1'b0));
                check($sformatf("%s dut_in_done", name), 32'(dut_in), 32'(pat[NP-1]));
                check($sformatf("%s sig_final", name), 32'(signature), 32'(sig_tab[NP]));
                start = hold;
                mode  = m;
            end
        end
        @(negedge clk);
        check($sformatf("%s done_low", name), 32'(done), 32'(1'b0));
        check($sformatf("%s busy_low", name), 32'(busy), 32'(1'b0));
        check($sformatf("%s pass", name), 32'(pass), 32'(sig_tab[NP] == gold));
        check($sformatf("%s dut_in_hold", name), 32'(dut_in), 32'(pat[NP-1]));
        $display("run %s: mode=%0d sig=%04h golden=%04h pass=%0d", name, m, signature, gold, pass);
    endtask

    task automatic idle_gap;
        start = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
    endtask

    initial begin
        logic [15:0] s_exp;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; golden_sig = 16'h0000; tie0 = 1'b1;
        s_start = 1'b0; s_mode = 1'b0; s_golden = 16'h0000;
        for (int i = 0; i < 32; i++) flip_tab[i] = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst dut_in", 32'(dut_in), 32'(5'd0));
        check("rst busy", 32'(busy), 32'(1'b0));
        check("rst done", 32'(done), 32'(1'b0));
        check("rst pass", 32'(pass), 32'(1'b0));
        check("rst sig", 32'(signature), 32'(16'h0000));
        check("rst idx", 32'(pattern_idx), 32'(5'd0));
        rst_n = 1'b1;
        @(negedge clk);

        // Small instance: 4 patterns, 2 settle cycles, dut_out held at 01.
        s_exp    = 16'h0000;
        for (int i = 0; i < 4; i++) s_exp = misr_step(s_exp, 2'b01);
        s_golden = s_exp;
        s_start  = 1'b1;
        s_exp    = 16'h0000;
        @(posedge clk);
        for (int j = 0; j <= 16; j++) begin
            @(negedge clk);
            s_start = 1'b0;
            if (j % 4 == 0) begin
                check($sformatf("small sig j=%0d", j), 32'(s_signature), 32'(s_exp));
                s_exp = misr_step(s_exp, 2'b01);
            end
            check($sformatf("small done j=%0d", j), 32'(s_done), 32'(j == 16));
        end
        @(negedge clk);
        check("small pass", 32'(s_pass), 32'(1'b1));
        $display("run small: sig=%04h pass=%0d", s_signature, s_pass);

        do_run("exh_gold0", 1'b0, 1'b0, 16'h0000, 1'b0);
        idle_gap();
        do_run("exh_gold1", 1'b0, 1'b0, 16'h0001, 1'b0);
        idle_gap();
        tie0 = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++) flip_tab[i] = 2'($urandom);
            do_run($sformatf("rand%0d", r), (r == 0) ? 1'b1 : 1'($urandom), 1'($urandom),
                   16'($urandom), 1'b0);
            idle_gap();
        end

        // Reset during SETTLE of pattern 7.
        start = 1'b1;
        mode  = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7 * PER + 5) @(negedge clk);
        check("pre_rst idx", 32'(pattern_idx), 32'(5'd7));
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst busy", 32'(busy), 32'(1'b0));
        check("midrst dut_in", 32'(dut_in), 32'(5'd0));
        check("midrst sig", 32'(signature), 32'(16'h0000));
        check("midrst idx", 32'(pattern_idx), 32'(5'd0));
        check("midrst done", 32'(done), 32'(1'b0));
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            check($sformatf("postrst done j=%0d", j), 32'(done), 32'(1'b0));
        end
        do_run("after_rst", 1'b0, 1'b1, 16'h0000, 1'b0);
        idle_gap();

        // Back-to-back: start stays high across the DONE/IDLE boundary.
        for (int i = 0; i < 32; i++) flip_tab[i] = 2'($urandom);
        do_run("hold_a", 1'b1, 1'b1, 16'h0000, 1'b1);
        do_run("hold_b", 1'b0, 1'b0, 16'($urandom), 1'b0);
        idle_gap();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
